// File: rtl/rs_pkg.sv
// rs_pkg: shared defaults and op codes for the ALU reservation station.
package rs_pkg;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_NCDB  = 2;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_ROBW  = 4;
    localparam int DEF_OPW   = 6;
    localparam logic [DEF_OPW-1:0] OP_NULL = '0;
    localparam logic [DEF_OPW-1:0] OP_ADD  = 6'd1;
endpackage

// File: rtl/rs_station_mc_if.sv
// rs_station_mc_if: dispatch, CDB snoop and issue bundle of the reservation station.
interface rs_station_mc_if #(
    parameter int DEPTH = rs_pkg::DEF_DEPTH,
    parameter int NCDB  = rs_pkg::DEF_NCDB,
    parameter int XLEN  = rs_pkg::DEF_XLEN,
    parameter int ROBW  = rs_pkg::DEF_ROBW,
    parameter int OPW   = rs_pkg::DEF_OPW
);
    logic                   in_valid, in_ready, in_src1_rdy, in_src2_rdy, in_use_imm;
    logic [OPW-1:0]         in_op;
    logic [XLEN-1:0]        in_src1, in_src2, in_imm;
    logic [ROBW-1:0]        in_rob_idx;
    logic [NCDB-1:0]        cdb_valid;
    logic [NCDB*ROBW-1:0]   cdb_idx;
    logic [NCDB*XLEN-1:0]   cdb_data;
    logic                   iss_valid, iss_ready;
    logic [OPW-1:0]         iss_op;
    logic [XLEN-1:0]        iss_val1, iss_val2;
    logic [ROBW-1:0]        iss_rob_idx;
    logic [$clog2(DEPTH):0] count;
    modport master (
        output in_valid, in_op, in_src1_rdy, in_src1, in_src2_rdy, in_src2, in_use_imm, in_imm,
               in_rob_idx, cdb_valid, cdb_idx, cdb_data, iss_ready,
        input  in_ready, iss_valid, iss_op, iss_val1, iss_val2, iss_rob_idx, count
    );
    modport slave (
        input  in_valid, in_op, in_src1_rdy, in_src1, in_src2_rdy, in_src2, in_use_imm, in_imm,
               in_rob_idx, cdb_valid, cdb_idx, cdb_data, iss_ready,
        output in_ready, iss_valid, iss_op, iss_val1, iss_val2, iss_rob_idx, count
    );
endinterface

// File: rtl/rs_prio_pick.sv
// rs_prio_pick: lowest-set-bit picker with binary index of the winner.
module rs_prio_pick #(
    parameter int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [N-1:0] onehot;
    assign onehot = req & (~req + N'(1));
    assign any = |req;
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) idx = onehot[i] ? (idx | W'(i)) : idx;
    end
endmodule

// File: rtl/rs_station_mc.sv
// rs_station_mc: ALU reservation station with CDB wakeup and one issue per cycle.
// Define RS_AGE_SELECT_EN for oldest-ready select; otherwise the lowest ready index wins.
module rs_station_mc import rs_pkg::*; #(
    parameter int DEPTH = DEF_DEPTH,
    parameter int NCDB  = DEF_NCDB,
    parameter int XLEN  = DEF_XLEN,
    parameter int ROBW  = DEF_ROBW,
    parameter int OPW   = DEF_OPW
) (
    input logic clk,
    input logic rst,
    input logic rdy,
    input logic flush,
    rs_station_mc_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    typedef struct packed {
        logic            used, r1, r2;
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] v1, v2;
        logic [ROBW-1:0] rob;
    } entry_t;
    entry_t               ent [DEPTH];
    logic [CW-1:0]        count;
    logic [DEPTH-1:0]     used, cand, pick_req;
    logic [IW-1:0]        sel_idx, free_idx;
    logic                 sel_any, free_any, do_disp, do_iss;
    logic [XLEN:0]        wk1 [DEPTH];
    logic [XLEN:0]        wk2 [DEPTH];
    logic [XLEN:0]        byp1, byp2;
    logic [NCDB-1:0]      cdb_v;
    logic [NCDB*ROBW-1:0] cdb_i;
    logic [NCDB*XLEN-1:0] cdb_d;
    assign cdb_v = bus.cdb_valid;
    assign cdb_i = bus.cdb_idx;
    assign cdb_d = bus.cdb_data;
    // {hit, data}; scanning high to low lets the lowest matching port win
    function automatic logic [XLEN:0] snoop(input logic [ROBW-1:0] tag);
        snoop = '0;
        for (int p = NCDB - 1; p >= 0; p--)
            if (cdb_v[p] && cdb_i[p*ROBW +: ROBW] == tag) snoop = {1'b1, cdb_d[p*XLEN +: XLEN]};
    endfunction
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            used[i] = ent[i].used;
            cand[i] = ent[i].used && ent[i].r1 && ent[i].r2;
            wk1[i]  = snoop(ent[i].v1[ROBW-1:0]);
            wk2[i]  = snoop(ent[i].v2[ROBW-1:0]);
        end
    end
    assign byp1 = snoop(bus.in_src1[ROBW-1:0]);
    assign byp2 = snoop(bus.in_src2[ROBW-1:0]);
`ifdef RS_AGE_SELECT_EN
    // age[i][j] set: entry i was dispatched after entry j
    logic [DEPTH-1:0] age [DEPTH];
    always_comb begin
        for (int i = 0; i < DEPTH; i++) pick_req[i] = cand[i] && !(|(age[i] & cand));
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) age[i] <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++)
                for (int j = 0; j < DEPTH; j++)
                    if (do_disp && free_idx == IW'(i)) age[i][j] <= used[j] && !(do_iss && sel_idx == IW'(j));
                    else if (do_iss && sel_idx == IW'(j)) age[i][j] <= 1'b0;
        end
    end
`else
    assign pick_req = cand;
`endif
    rs_prio_pick #(.N(DEPTH)) u_free (.req(~used), .idx(free_idx), .any(free_any));
    rs_prio_pick #(.N(DEPTH)) u_sel (.req(pick_req), .idx(sel_idx), .any(sel_any));
    assign bus.in_ready    = rdy && free_any;
    assign bus.iss_valid   = rdy && sel_any;
    assign bus.iss_op      = sel_any ? ent[sel_idx].op : OPW'(OP_NULL);
    assign bus.iss_val1    = sel_any ? ent[sel_idx].v1 : '0;
    assign bus.iss_val2    = sel_any ? ent[sel_idx].v2 : '0;
    assign bus.iss_rob_idx = sel_any ? ent[sel_idx].rob : '0;
    assign bus.count       = count;
    assign do_disp = bus.in_valid && bus.in_ready && !flush;
    assign do_iss  = bus.iss_valid && bus.iss_ready && !flush;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i].used <= 1'b0;
        end else if (rdy) begin
            count <= count + CW'(do_disp) - CW'(do_iss);
            for (int i = 0; i < DEPTH; i++) begin
                if (!ent[i].r1 && wk1[i][XLEN]) begin
                    ent[i].v1 <= wk1[i][XLEN-1:0];
                    ent[i].r1 <= 1'b1;
                end
                if (!ent[i].r2 && wk2[i][XLEN]) begin
                    ent[i].v2 <= wk2[i][XLEN-1:0];
                    ent[i].r2 <= 1'b1;
                end
            end
            if (do_iss) ent[sel_idx].used <= 1'b0;
            if (do_disp) ent[free_idx] <= '{
                used: 1'b1,
                r1:   bus.in_src1_rdy || byp1[XLEN],
                r2:   bus.in_use_imm || bus.in_src2_rdy || byp2[XLEN],
                op:   bus.in_op,
                v1:   bus.in_src1_rdy ? bus.in_src1 : byp1[XLEN] ? byp1[XLEN-1:0] : bus.in_src1,
                v2:   bus.in_use_imm ? bus.in_imm : bus.in_src2_rdy ? bus.in_src2 :
                      byp2[XLEN] ? byp2[XLEN-1:0] : bus.in_src2,
                rob:  bus.in_rob_idx
            };
        end
    end
endmodule
